// File: rtl/tsn_queue_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tsn_queue_scheduler
// Purpose : Frame-granular read scheduler that drains NUM_Q standard-mode
//           (1-cycle read latency) sync FIFOs onto one valid/ready stream.
//           One queue is granted per frame (round robin or strict priority).
//           A 2-entry output buffer absorbs read latency and backpressure.
// Revision: 1.0 - initial release
// ============================================================================
module tsn_queue_scheduler #(
  parameter int NUM_Q = 4,
  parameter int WIDTH = 65,
  parameter int QID_W = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_Q-1:0]       i_q_empty,
  output logic [NUM_Q-1:0]       o_q_rd_en,
  input  logic [NUM_Q*WIDTH-1:0] i_q_dout,
  input  logic [NUM_Q-1:0]       i_q_enable,
  input  logic                   i_sp_mode,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-2:0]       o_data,
  output logic                   o_last,
  output logic [QID_W-1:0]       o_qid,
  output logic                   o_busy
);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t           r_state;
  logic [QID_W-1:0] r_grant;
  logic [QID_W-1:0] r_rr_ptr;
  logic             r_inflight;

  logic [WIDTH-2:0] r_buf_data [2];
  logic [QID_W-1:0] r_buf_qid  [2];
  logic [1:0]       r_buf_last;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_cnt;

  logic [NUM_Q-1:0] w_cand;
  logic             w_any;
  logic [QID_W-1:0] w_sp_grant;
  logic [QID_W-1:0] w_rr_grant;
  logic [QID_W-1:0] w_arb_grant;
  int               w_rr_dist;
  int               w_rr_best;
  logic [WIDTH-1:0] w_cap_word;
  logic             w_g_empty;
  logic             w_eof_seen;
  logic             w_pop;
  logic             w_push;
  logic [2:0]       w_occ;
  logic             w_rd_ok;

  assign w_cand      = ~i_q_empty & i_q_enable;
  assign w_any       = |w_cand;
  assign w_arb_grant = i_sp_mode ? w_sp_grant : w_rr_grant;

  // Strict priority: lowest-index candidate wins (scan downward, last hit wins)
  always_comb begin
    w_sp_grant = '0;
    for (int q = NUM_Q - 1; q >= 0; q--) begin
      if (w_cand[q]) w_sp_grant = QID_W'(q);
    end
  end

  // Round robin: candidate with the smallest cyclic distance from the pointer
  always_comb begin
    w_rr_grant = '0;
    w_rr_best  = NUM_Q;
    w_rr_dist  = 0;
    for (int q = 0; q < NUM_Q; q++) begin
      w_rr_dist = (q >= int'(r_rr_ptr)) ? (q - int'(r_rr_ptr))
                                        : (q + NUM_Q - int'(r_rr_ptr));
      if (w_cand[q] && (w_rr_dist < w_rr_best)) begin
        w_rr_best  = w_rr_dist;
        w_rr_grant = QID_W'(q);
      end
    end
  end

  // Select the granted queue's read data and empty flag
  always_comb begin
    w_cap_word = '0;
    w_g_empty  = 1'b1;
    for (int q = 0; q < NUM_Q; q++) begin
      if (r_grant == QID_W'(q)) begin
        w_cap_word = i_q_dout[q*WIDTH +: WIDTH];
        w_g_empty  = i_q_empty[q];
      end
    end
  end

  // Words already committed (buffered + in flight) after this cycle's pop must
  // leave room for one more; never read past a word known to end the frame.
  assign w_pop      = o_valid & i_ready;
  assign w_push     = r_inflight;
  assign w_eof_seen = r_inflight & w_cap_word[WIDTH-1];
  assign w_occ      = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_ok    = (r_state == ST_XFER) & ~w_g_empty & (w_occ < 3'd2) & ~w_eof_seen;

  // Steer the single read enable to the granted queue
  always_comb begin
    o_q_rd_en = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      if (r_grant == QID_W'(q)) o_q_rd_en[q] = w_rd_ok;
    end
  end

  // Arbitration / transfer FSM with read-latency tracking
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_ARB;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_ok;
      case (r_state)
        ST_ARB: begin
          if (w_any) begin
            r_grant <= w_arb_grant;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_eof_seen) begin
            r_state  <= ST_ARB;
            r_rr_ptr <= (r_grant == QID_W'(NUM_Q - 1)) ? '0 : r_grant + 1'b1;
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  // Two-entry output FIFO: push on captured read data, pop on egress handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_qid[i]  <= '0;
      end
      r_buf_last <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= w_cap_word[WIDTH-2:0];
        r_buf_last[r_wr_ptr] <= w_cap_word[WIDTH-1];
        r_buf_qid[r_wr_ptr]  <= r_grant;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_buf_data[r_rd_ptr];
  assign o_last  = r_buf_last[r_rd_ptr];
  assign o_qid   = r_buf_qid[r_rd_ptr];
  assign o_busy  = (r_state == ST_XFER) | (r_cnt != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_tsn_queue_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_tsn_queue_scheduler
// Purpose : Scoreboard bench for tsn_queue_scheduler. Queue FIFOs are modelled
//           in the bench; a frame-level arbitration model predicts the egress
//           word sequence, and a negedge monitor compares every handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tsn_queue_scheduler;
  localparam int NQ = 4;
  localparam int W  = 65;
  localparam int QW = 3;

  typedef logic [W-1:0] word_t;
  typedef struct {
    logic [W-2:0] d;
    logic         l;
    int           q;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NQ-1:0]   q_empty = '1;
  logic [NQ-1:0]   rd_en;
  logic [NQ*W-1:0] q_dout_bus = '0;
  logic [NQ-1:0]   q_en = '1;
  logic            sp = 1'b0;
  logic            valid;
  logic            ready = 1'b1;
  logic [W-2:0]    data;
  logic            last;
  logic [QW-1:0]   qid;
  logic            busy;

  word_t fifo [NQ][$];
  word_t mfr  [NQ][$];
  word_t q_dout [NQ];
  exp_t  exq [$];
  int    pop_cyc [$];

  int n_chk = 0, n_pass = 0;
  int cyc_n = 0, n_rd = 0, n_pop = 0, outst = 0;
  int mptr = 0, rdy_mode = 0, rp = 0;
  logic          stall_prev = 1'b0;
  logic [W-2:0]  stall_data = '0;
  logic [NQ-1:0] no_rd_mask = '0;
  logic [NQ-1:0] mon_rd;
  logic          mon_pop;
  exp_t          mon_e;

  tsn_queue_scheduler #(.NUM_Q(NQ), .WIDTH(W), .QID_W(QW)) dut (
    .i_clk(clk), .i_rst(rst), .i_q_empty(q_empty), .o_q_rd_en(rd_en),
    .i_q_dout(q_dout_bus), .i_q_enable(q_en), .i_sp_mode(sp),
    .o_valid(valid), .i_ready(ready), .o_data(data), .o_last(last),
    .o_qid(qid), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
  endtask

  function automatic word_t mkw(input bit eof);
    word_t w;
    w[W-2:0] = {$urandom(), $urandom()};
    w[W-1]   = eof;
    return w;
  endfunction

  task automatic upd();
    for (int q = 0; q < NQ; q++) begin
      q_empty[q] = (fifo[q].size() == 0);
      q_dout_bus[q*W +: W] = q_dout[q];
    end
  endtask

  // One clock: rd_en sampled at the negedge, FIFO reads applied after the edge
  task automatic cyc();
    logic [NQ-1:0] rs;
    @(negedge clk);
    rs = rd_en;
    @(posedge clk);
    #1;
    for (int q = 0; q < NQ; q++)
      if (rs[q] && fifo[q].size() != 0) q_dout[q] = fifo[q].pop_front();
    case (rdy_mode)
      0:       ready = 1'b1;
      1:       ready = ((rp % 4) == 0) || ((rp % 4) == 3);
      default: ready = ($urandom_range(0, 1) == 1);
    endcase
    rp++;
    upd();
  endtask

  task automatic add_frame(input int q, input int len);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w = mkw(i == len - 1);
      fifo[q].push_back(w);
      mfr[q].push_back(w);
    end
  endtask

  task automatic flush();
    for (int q = 0; q < NQ; q++) begin
      fifo[q].delete();
      mfr[q].delete();
    end
    upd();
  endtask

  // Frame-level reference: pick a queue by rule, emit its whole frame, advance pointer
  task automatic predict(input logic sp_m, input logic [NQ-1:0] msk);
    int g, idx;
    word_t w;
    forever begin
      g = -1;
      for (int k = 0; k < NQ; k++) begin
        idx = sp_m ? k : (mptr + k) % NQ;
        if (g < 0 && (((msk >> idx) & 1) != 0) && mfr[idx].size() != 0) g = idx;
      end
      if (g < 0) break;
      do begin
        w = mfr[g].pop_front();
        exq.push_back('{d: w[W-2:0], l: w[W-1], q: g});
      end while (!w[W-1] && mfr[g].size() != 0);
      mptr = (g + 1) % NQ;
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exq.size() != 0 || busy) && n < 3000) begin
      cyc();
      n++;
    end
    chk({nm, "_drain_timeout"}, n < 3000, 1);
    repeat (2) cyc();
  endtask

  // Monitor: handshake scoreboard, hold-under-stall, outstanding-read bound
  always @(negedge clk) begin
    if (rst) begin
      outst      = 0;
      stall_prev = 1'b0;
    end else begin
      mon_rd  = rd_en;
      mon_pop = valid & ready;
      if (stall_prev) begin
        chk("stall_hold_valid", valid, 1);
        chk("stall_hold_data", data, stall_data);
      end
      stall_prev = valid & ~ready;
      stall_data = data;
      outst = outst + $countones(mon_rd) - (mon_pop ? 1 : 0);
      chk("outstanding_le2_onehot", (outst <= 2) && ($countones(mon_rd) <= 1), 1);
      if (no_rd_mask != '0) chk("no_rd_en", mon_rd & no_rd_mask, 0);
      n_rd += $countones(mon_rd);
      if (mon_pop) begin
        n_pop++;
        pop_cyc.push_back(cyc_n);
        if (exq.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          mon_e = exq.pop_front();
          chk("data", data, mon_e.d);
          chk("last", last, mon_e.l);
          chk("qid", qid, mon_e.q);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bp, ld, rd0, n, nf;
    logic [NQ-1:0] msk;
    word_t fr [$];
    for (int q = 0; q < NQ; q++) q_dout[q] = '0;
    upd();
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("reset_valid", valid, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data", data, 0);
    chk("reset_last", last, 0);
    chk("reset_qid", qid, 0);

    // Round-robin fairness: two 3-word frames per queue
    for (int f = 0; f < 2; f++)
      for (int q = 0; q < NQ; q++) add_frame(q, 3);
    upd();
    ld = cyc_n;
    bp = pop_cyc.size();
    predict(1'b0, '1);
    drain("rr");
    chk("rr_word_count", pop_cyc.size() - bp, 24);
    chk("rr_first_latency", (pop_cyc.size() > bp) ? pop_cyc[bp] - ld : -1, 3);

    // Strict priority with q0 refilled while q3 waits
    sp = 1'b1;
    add_frame(0, 3);
    add_frame(0, 3);
    add_frame(3, 3);
    fr.delete();
    for (int i = 0; i < 3; i++) begin
      fr.push_back(mkw(i == 2));
      mfr[0].push_back(fr[i]);
    end
    upd();
    predict(1'b1, '1);
    repeat (2) cyc();
    for (int i = 0; i < 3; i++) fifo[0].push_back(fr[i]);
    upd();
    drain("sp");
    sp = 1'b0;

    // Backpressure: 8-word frame with ready pattern 1,0,0,1
    rdy_mode = 1;
    rp = 0;
    add_frame(1, 8);
    upd();
    predict(1'b0, '1);
    drain("bp");
    rdy_mode = 0;

    // Single-word frames: one read per frame, one ARB bubble between frames
    bp  = pop_cyc.size();
    rd0 = n_rd;
    for (int i = 0; i < 4; i++) add_frame(2, 1);
    upd();
    predict(1'b0, '1);
    drain("single");
    chk("single_rd_count", n_rd - rd0, 4);
    chk("single_pop_count", pop_cyc.size() - bp, 4);
    for (int i = 1; i < 4; i++)
      chk("single_frame_spacing",
          (pop_cyc.size() > bp + i) ? pop_cyc[bp+i] - pop_cyc[bp+i-1] : -1, 3);

    // Randomized phases: mode, mask, frame counts/lengths, ready behaviour
    for (int ph = 0; ph < 8; ph++) begin
      sp       = ($urandom_range(0, 1) == 1);
      msk      = NQ'($urandom());
      rdy_mode = $urandom_range(0, 2);
      q_en     = msk;
      for (int q = 0; q < NQ; q++) begin
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) add_frame(q, $urandom_range(1, 6));
      end
      upd();
      predict(sp, msk);
      drain("rand");
      flush();
      q_en     = '1;
      sp       = 1'b0;
      rdy_mode = 0;
      cyc();
    end

    // Mid-frame underflow with mask cleared during the gap
    fr.delete();
    for (int i = 0; i < 5; i++) begin
      fr.push_back(mkw(i == 4));
      mfr[1].push_back(fr[i]);
    end
    fifo[1].push_back(fr[0]);
    fifo[1].push_back(fr[1]);
    upd();
    predict(1'b0, '1);
    n = 0;
    while (fifo[1].size() != 0 && n < 50) begin
      cyc();
      n++;
    end
    chk("uf_first_words_read", n < 50, 1);
    q_en[1]    = 1'b0;
    no_rd_mask = '1;
    repeat (10) cyc();
    no_rd_mask = '0;
    for (int i = 2; i < 5; i++) fifo[1].push_back(fr[i]);
    upd();
    drain("uf");
    add_frame(1, 2);
    upd();
    no_rd_mask = '1;
    repeat (20) cyc();
    no_rd_mask = '0;
    flush();
    q_en = '1;
    cyc();

    // Reset mid-frame on word 2 of 6; pointer must restart at queue 0
    bp = n_pop;
    add_frame(2, 6);
    upd();
    predict(1'b0, '1);
    n = 0;
    while (n_pop - bp < 2 && n < 50) begin
      cyc();
      n++;
    end
    chk("rst_word2_reached", n < 50, 1);
    rst = 1'b1;
    exq.delete();
    flush();
    mptr = 0;
    cyc();
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_rd_en", rd_en, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 1'b0;
    cyc();
    add_frame(3, 2);
    add_frame(0, 2);
    upd();
    predict(1'b0, '1);
    drain("rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tsn_queue_scheduler.md
Name: tsn_queue_scheduler

Overview:
- Frame-granular read scheduler that drains NUM_Q standard-mode (non-FWFT) sync FIFO queues onto one valid/ready egress stream.
- Sits between the per-priority egress queues of a switch port and the MAC transmit path.
- Grants one queue per frame, in either round-robin or strict-priority order, and issues that queue's read enables.
- Absorbs the queues' 1-cycle read latency and downstream backpressure with a 2-entry output buffer.

Parameters:
- NUM_Q, 4, number of queues (2..8)
- WIDTH, 65, queue word width; bit WIDTH-1 is the end-of-frame flag, bits WIDTH-2:0 are payload
- QID_W, 3, width of the queue index output; must satisfy 2**QID_W >= NUM_Q

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_q_empty  in  NUM_Q  per-queue empty flag
- o_q_rd_en  out  NUM_Q  per-queue read enable; at most one bit set per cycle
- i_q_dout  in  NUM_Q*WIDTH  queue read data; queue q occupies slice [q*WIDTH +: WIDTH]; valid the cycle after that queue's rd_en
- i_q_enable  in  NUM_Q  per-queue eligibility mask (gate-control input)
- i_sp_mode  in  1  1 = strict priority (queue 0 highest), 0 = round robin
- o_valid  out  1  egress word valid
- i_ready  in  1  egress ready
- o_data  out  WIDTH-1  egress payload
- o_last  out  1  egress end-of-frame
- o_qid  out  QID_W  source queue of the current egress word
- o_busy  out  1  frame in progress or output buffer non-empty

Behaviour:
- Reset: every output is 0; state = ARB; RR pointer = 0; buffer empty; no read in flight. A reset asserted mid-frame discards the partial frame and the buffer contents; the first cycle after reset issues no rd_en.
- States: ARB and XFER.
- ARB: candidates = ~i_q_empty & i_q_enable.
  - i_sp_mode=1: grant the lowest-index candidate.
  - i_sp_mode=0: grant the first candidate at or cyclically after the RR pointer.
  - With no candidate, remain in ARB.
  - Latch grant g and go to XFER. ARB issues no rd_en.
- XFER read issue: o_q_rd_en[g] = ~i_q_empty[g] & (buf_cnt + inflight - pop < 2) & ~eof_seen.
  - pop = o_valid & i_ready.
  - eof_seen = inflight & i_q_dout[g][WIDTH-1].
  - No read is ever issued past the last word of the frame.
- Capture: inflight is a register equal to the previous cycle's rd_en. When inflight=1, i_q_dout[g] and g are written into the buffer tail in that cycle.
- Frame end: a captured word with the EOF flag set returns the FSM to ARB on the next cycle, and RR pointer = (g+1) mod NUM_Q. In SP mode the pointer is also updated but ignored. This costs one arbitration bubble per frame.
- Queue empty mid-frame: stall in XFER with no rd_en until the queue refills. No timeout.
- i_q_enable deasserted mid-frame: the frame still completes; the mask applies only in ARB.
- Output buffer: 2-entry FIFO.
  - o_valid = buf_cnt != 0; o_data, o_last and o_qid come from the head entry.
  - Push and pop in the same cycle leave the count unchanged.
  - Overflow cannot occur by construction; the bench asserts it never does.
  - Head data stays stable while o_valid & ~i_ready.
- Throughput: 1 word/cycle sustained inside a frame when i_ready=1 and the queue is non-empty.
- Latency: first word is visible on o_valid 3 cycles after the candidate appears in ARB (ARB, rd_en, capture into the buffer).
- o_busy = (state==XFER) | (buf_cnt != 0).

Test Plan:
- RR fairness: queues 0..3 each preloaded with two 3-word frames, i_ready=1 -> frame order q0,q1,q2,q3,q0,q1,q2,q3; 24 words; o_last on every 3rd word; o_qid matches the source.
- Strict priority: q0 holds 2 frames, q3 holds 1; i_sp_mode=1; q0 refilled with 1 new frame while q3 is waiting -> order q0,q0,q0,q3. q3 is served only when q0 is empty at ARB.
- Backpressure: 8-word frame, i_ready toggling 1,0,0,1 -> all 8 words delivered in order with none dropped or duplicated; never more than 2 reads outstanding plus buffered; the stalled word holds its o_data.
- Mid-frame underflow and mask: q1 frame of 5 words with only 2 written, then a 10-cycle gap, then the rest; i_q_enable[1] cleared during the gap -> no rd_en during the gap; the frame completes with 5 words; q1 is not re-granted afterwards while masked.
- Single-word frames: q2 holds four 1-word frames, i_ready=1 -> exactly one rd_en per frame, each word with o_last=1, one ARB bubble between frames.
- Reset mid-frame: i_rst asserted on word 2 of 6 -> the next cycle shows o_valid=0, o_q_rd_en=0, o_busy=0; after release, arbitration restarts with the RR pointer at queue 0.
